spi_master_tx: RTL and testbench
================================

// Module: spi_master_tx
// PURPOSE
//  SPI mode-0 (CPOL=0, CPHA=0) initiator. Generates sck/cs_n from the system clock and shifts
//  one WIDTH-bit word out MSB-first on mosi per frame.
//  Drives the 16-bit SPI receiver block (its miso input = our mosi) for on-chip loopback,
//  and drives external SPI peripherals.
//  Host side uses a valid/ready handshake plus a one-cycle done pulse.
// PARAMETERS
//  WIDTH    16  bits per frame (>=2)
//  CLK_DIV  4   clk cycles per sck half-period (>=1)
// PORTS
//  clk       in   1      system clock; all logic on posedge
//  rst_n     in   1      synchronous, active-low reset
//  tx_data   in   WIDTH  word to send; sampled only on accept
//  tx_valid  in   1      host has a word
//  tx_ready  out  1      high only in IDLE; accept = tx_valid & tx_ready
//  sck       out  1      SPI clock, idles low, registered
//  cs_n      out  1      chip select, active low, registered
//  mosi      out  1      serial data out, registered
//  miso      in   1      serial data in (used only with SPI_MASTER_RX_EN)
//  rx_data   out  WIDTH  word captured from miso, valid from done onward
//  busy      out  1      high in SETUP/SHIFT/HOLD/GAP
//  done      out  1      one-cycle pulse in the cycle cs_n returns high
// BEHAVIOUR
//  - Reset (rst_n=0 at a posedge), next cycle: state=IDLE, cs_n=1, sck=0, mosi=0, busy=0,
//    done=0, rx_data=0, tx_ready=1. Reset mid-frame aborts the frame immediately;
//    the frame gets no done pulse and no GAP.
//  - Divider: div_cnt counts 0..CLK_DIV-1. tick = (div_cnt==CLK_DIV-1). div_cnt clears on every
//    state change. Bit counter width $clog2(WIDTH+1).
//  - FSM, accept at cycle N:
//    IDLE  -> SETUP on accept. Load shreg=tx_data. At N+1: cs_n=0, sck=0, mosi=tx_data[WIDTH-1].
//    SETUP -> SHIFT after CLK_DIV cycles (one half-period of mosi setup before first rise).
//    SHIFT -> each tick toggles sck.
//             On 0->1: bit count +1.
//             On 1->0: shreg shifts left; mosi takes the next bit.
//             After the WIDTH-th fall (mosi unchanged on that fall) -> HOLD.
//    HOLD  -> CLK_DIV cycles with cs_n=0, sck=0, then cs_n=1 and done=1 (one cycle) -> GAP.
//    GAP   -> CLK_DIV cycles with cs_n=1, tx_ready=0, then IDLE.
//  - Timing: cs_n low for cycles N+1..N+CLK_DIV*(2*WIDTH+2). done at N+CLK_DIV*(2*WIDTH+2)+1.
//    tx_ready re-asserts at N+CLK_DIV*(2*WIDTH+3)+1.
//  - Exactly WIDTH rising sck edges per frame. mosi is stable a full half-period around each rise.
//  - tx_valid while tx_ready=0 is ignored. tx_data changes after accept have no effect.
//  - Back-to-back: tx_valid held high gives minimum cs_n-high time of CLK_DIV+1 cycles
//    between frames.
// CONFIGURATION
//  SPI_MASTER_RX_EN defined:
//    - miso is sampled into rx shreg in the clk cycle whose edge drives sck 0->1, MSB first.
//    - rx_data updates with done and holds until the next done or reset.
//  SPI_MASTER_RX_EN undefined:
//    - no capture logic; rx_data tied to 0; miso unused. Port list unchanged.
// TESTING (WIDTH=16, CLK_DIV=4 unless stated)
//  1 Reset: rst_n=0 for 2 cycles, release -> cs_n=1, sck=0, mosi=0, busy=0, done=0, tx_ready=1.
//  2 Single frame: tx_data=16'hA5C3 accepted at N -> cs_n low N+1..N+136; 16 sck rises;
//    mosi at rises = 1010_0101_1100_0011; done at N+137; attached 16-bit receiver reports
//    16'hA5C3 with data_rdy=1.
//  3 Back-to-back: tx_valid held high with words 16'h0001, 16'h8000 -> cs_n high N+137..N+140;
//    second frame accepted at N+141; 0001 then 8000 on mosi.
//  4 Ignore while busy: pulse tx_valid with 16'hFFFF, and change tx_data, during bit 5
//    -> frame still 16'hA5C3; no extra frame.
//  5 Reset mid-frame at the 8th sck rise -> next cycle cs_n=1, sck=0, done never pulses;
//    then a new frame 16'h1234 completes normally.
//  6 SPI_MASTER_RX_EN: miso bit-serial 16'h3C5A aligned to falls -> rx_data=16'h3C5A at done.
//    Macro undefined -> rx_data=0 throughout.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: shifts one WIDTH-bit word MSB-first on mosi per cs_n frame.
// Optional miso capture into rx_data is enabled by defining SPI_MASTER_RX_EN.
module spi_master_tx #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sck,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               tx_ready_q, tx_ready_d;
    logic               tick_c;
    logic               rise_c;

    assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));
    // Edge that drives sck 0->1 inside SHIFT; also the miso sampling point.
    assign rise_c = (state_q == S_SHIFT) && tick_c && !sck_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_SETUP;
                    shreg_d = tx_data;
                    mosi_d  = tx_data[WIDTH-1];
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (tick_c) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (tick_c) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        bit_d = bit_q + CNT_W'(1);
                    end else begin
                        sck_d = 1'b0;
                        // Last fall leaves mosi on the final bit and ends the shift phase.
                        if (bit_q == CNT_W'(WIDTH)) begin
                            state_d = S_HOLD;
                        end else begin
                            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                            mosi_d  = shreg_q[WIDTH-2];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick_c) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (tick_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) div_d = '0;

        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    // Capture miso on each sck rise; publish the word together with done.
    always_comb begin
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        if (rise_c) rx_shreg_d = {rx_shreg_q[WIDTH-2:0], miso};
        if (done_d) rx_data_d = rx_shreg_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_shreg_q <= rx_shreg_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_rx_c;
    assign unused_rx_c = miso ^ rise_c;
    assign rx_data     = '0;
`endif

    assign tx_ready = tx_ready_q;
    assign sck      = sck_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx (WIDTH=16, CLK_DIV=4): frame timing, back-to-back,
// ignore-while-busy, mid-frame reset, and miso capture when SPI_MASTER_RX_EN is defined.
module tb_spi_master_tx;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CLK_DIV = 4;
`ifdef SPI_MASTER_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sck;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [WIDTH-1:0]  rx_data;
    logic              busy;
    logic              done;

    spi_master_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] miso_word;
        logic        hold_valid;
        logic [15:0] next_data;
        int          inject_rise;
        logic [15:0] exp_word;
    } vec_t;

    typedef struct {
        logic [15:0] got;
        logic [15:0] rx_at_done;
        int          rises;
        int          cs_low;
        int          first_low;
        int          last_low;
        int          done_at;
        int          done_cnt;
        int          ready_at;
        int          mosi_bad;
    } res_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame from a negedge and observe it cycle by cycle until tx_ready returns.
    task automatic run_frame(input vec_t v, output res_t r);
        int   guard;
        logic prev_sck;
        logic prev_mosi;
        logic pulse;
        r        = '{default: 0};
        guard    = 0;
        pulse    = 1'b0;
        while (tx_ready !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(guard < 400), 32'd1);
        tx_data  = v.data;
        tx_valid = 1'b1;
        miso     = v.miso_word[15];
        @(posedge clk);
        @(negedge clk);
        tx_valid = v.hold_valid;
        if (v.hold_valid) tx_data = v.next_data;
        prev_sck  = 1'b0;
        prev_mosi = mosi;
        for (int k = 1; k <= 300; k++) begin
            if (pulse) begin
                tx_valid = 1'b0;
                pulse    = 1'b0;
            end
            if (!cs_n) begin
                r.cs_low++;
                if (r.first_low == 0) r.first_low = k;
                r.last_low = k;
            end
            if (k > 1 && mosi !== prev_mosi && !(prev_sck && !sck)) r.mosi_bad++;
            if (sck && !prev_sck) begin
                r.got = {r.got[14:0], mosi};
                r.rises++;
                if (v.inject_rise != 0 && r.rises == v.inject_rise) begin
                    tx_valid = 1'b1;
                    tx_data  = 16'hFFFF;
                    pulse    = 1'b1;
                end
            end
            if (!sck && prev_sck && r.rises < 16) miso = v.miso_word[15 - r.rises];
            if (done) begin
                r.done_cnt++;
                if (r.done_at == 0) begin
                    r.done_at    = k;
                    r.rx_at_done = rx_data;
                end
            end
            if (tx_ready && r.ready_at == 0) begin
                r.ready_at = k;
                break;
            end
            prev_sck  = sck;
            prev_mosi = mosi;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input vec_t v, input res_t r);
        check($sformatf("word_%h", v.data), 32'(r.got), 32'(v.exp_word));
        check("sck_rises", 32'(r.rises), 32'd16);
        check("cs_first_low", 32'(r.first_low), 32'd1);
        check("cs_last_low", 32'(r.last_low), 32'd136);
        check("cs_low_cycles", 32'(r.cs_low), 32'd136);
        check("done_cycle", 32'(r.done_at), 32'd137);
        check("done_pulses", 32'(r.done_cnt), 32'd1);
        check("ready_cycle", 32'(r.ready_at), 32'd141);
        check("rx_at_done", 32'(r.rx_at_done), RX_EN ? 32'(v.miso_word) : 32'd0);
        check("mosi_stable", 32'(r.mosi_bad), 32'd0);
    endtask

    initial begin
        res_t r;
        int   rises;
        int   guard;
        int   cnt_low;
        int   cnt_done;
        logic prev_sck;

        vecs[0] = '{16'hA5C3, 16'h3C5A, 1'b0, 16'h0000, 0, 16'hA5C3};
        vecs[1] = '{16'h0001, 16'hFFFF, 1'b1, 16'h8000, 0, 16'h0001};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h0000, 0, 16'h8000};
        vecs[3] = '{16'hA5C3, 16'h0000, 1'b0, 16'h0000, 5, 16'hA5C3};
        vecs[4] = '{16'h1234, 16'h8001, 1'b0, 16'h0000, 0, 16'h1234};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        miso     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], r);
            check_frame(vecs[i], r);
        end

        // The pulse during bit 5 must not have started another frame.
        cnt_low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!cs_n) cnt_low++;
        end
        check("no_extra_frame", 32'(cnt_low), 32'd0);

        // Reset asserted at the 8th sck rise aborts the frame without done.
        tx_data  = 16'h5A5A;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        rises    = 0;
        guard    = 0;
        prev_sck = 1'b0;
        cnt_done = 0;
        while (rises < 8 && guard < 300) begin
            if (sck && !prev_sck) rises++;
            if (done) cnt_done++;
            prev_sck = sck;
            if (rises < 8) @(negedge clk);
            guard++;
        end
        check("midrst_reach_rise8", 32'(rises), 32'd8);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sck", 32'(sck), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        cnt_low = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) cnt_done++;
            if (!cs_n) cnt_low++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(cnt_done), 32'd0);
        check("midrst_no_cs", 32'(cnt_low), 32'd0);

        run_frame(vecs[4], r);
        check_frame(vecs[4], r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
